charbuf_port_ctrl: RTL and testbench
====================================

# charbuf_port_ctrl

Port-A controller for the 4096 x 8 text-mode character buffer. It shares the buffer's CPU-side port between 6502 bus accesses and a hardware engine that clears the screen, scrolls it up one text row, and fills a single row. The video scan-out keeps exclusive use of port B and is not touched by this block. It sits between the CPU bus decoder, the console control registers that issue commands, and the character buffer RAM.

## Interface

Parameters:
- COLS, 80, characters per text row.
- ROWS, 30, text rows. COLS*ROWS must be ≤ 4096; smaller values are allowed.

Ports:
- clk  in  1  system clock, shared with the RAM's port-A clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  one-cycle access strobe. Back-to-back strobes are legal.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  12  buffer address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid only while cpu_ack = 1.
- cpu_ack  out  1  asserted in the cycle after every cpu_req.
- cmd_valid  in  1  command strobe.
- cmd_op  in  2  01 = clear, 10 = scroll up, 11 = fill row, 00 = no-op.
- cmd_fill  in  8  fill character, latched when the command is accepted.
- cmd_row  in  5  target row for fill row, latched when the command is accepted.
- cmd_ready  out  1  equals !busy.
- busy  out  1  high while the engine is running.
- done  out  1  one-cycle pulse when a command completes.
- ram_ce, ram_we  out  1  port-A enables.
- ram_addr  out  12  port-A address.
- ram_din  out  8  port-A write data.
- ram_dout  in  8  port-A read data. Synchronous RAM: data is valid 1 cycle after the read edge.

## Operation

**Port-A arbitration (combinational mux)**
- The CPU has absolute priority. When cpu_req = 1, the CPU fields drive ram_ce, ram_we, ram_addr and ram_din, and the engine holds its state and counters.
- Otherwise the engine drives the port. When the engine is idle, ram_ce = 0.
- ram_ce and ram_we are forced to 0 while reset is high.
- cpu_ack is cpu_req registered. cpu_rdata = ram_dout.

**Command acceptance**
- A command is accepted when cmd_valid && cmd_ready.
- cmd_op = 00 is ignored: no busy, no done.
- fill row with cmd_row ≥ ROWS is accepted but performs no writes. done pulses in the next cycle and busy never rises.

**FSM**
- IDLE to CLEAR, SCR_RD or FILL on acceptance. Counter idx is set to 0, or to cmd_row*COLS for FILL.
- CLEAR: one granted cycle writes cmd_fill at idx, then idx++. The write at idx = COLS*ROWS-1 leads to DONE.
- SCR_RD: one granted cycle reads idx+COLS, then moves to SCR_WR.
  - In the cycle after any engine read, ram_dout is latched into a hold register unconditionally, even if the CPU owns the port that cycle.
- SCR_WR: one granted cycle writes hold at idx, then idx++.
  - If idx was COLS*(ROWS-1)-1, go to FILL with idx = COLS*(ROWS-1).
  - Otherwise go back to SCR_RD.
- FILL: one granted cycle writes cmd_fill at idx, then idx++. The write at the last cell of the row leads to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Address arithmetic is 12-bit unsigned. The parameter constraint guarantees no wrap.

**Reset**
- reset is asynchronous. State goes to IDLE and all registers go to 0.
- Output values during reset: cpu_ack 0, cpu_rdata = ram_dout, busy 0, done 0, cmd_ready 1, ram_ce 0, ram_we 0, ram_addr 0 (or cpu_addr), ram_din 0 (or cpu_wdata).
- Reset mid-command leaves the buffer partially modified. No recovery is attempted.

## Timing

- CPU access: cpu_req at cycle t produces the RAM edge at the end of t. cpu_ack and cpu_rdata are valid at t+1.
- A CPU write followed by a read of the same address in the next cycle returns the new data, because the RAM is in normal read mode.
- Command accepted at edge t: busy = 1 from t+1, and the first engine RAM access is in cycle t+1.
- Each CPU cycle during a command adds exactly one cycle to its length.

Uncontended command lengths, from busy rising to done, for 80x30:
- clear: COLS*ROWS = 2400 access cycles, then 1 DONE cycle.
- scroll: 2*COLS*(ROWS-1) + COLS = 4720 access cycles, then 1 DONE cycle.
- fill row: COLS = 80 access cycles, then 1 DONE cycle.
- done falls and busy falls on the same edge, so cmd_ready = 1 in the cycle after done.

## Test plan

1. **Clear.** Preload a pattern, issue clear with fill 0x20. Required: exactly 2400 writes, all 2400 cells read back 0x20, and done at busy-cycle 2401.
2. **Scroll.** Set cell r*80+c = r for every cell, issue scroll with fill 0x00. Required: row r reads r+1 for r < 29, row 29 reads 0x00, and done after 4720 access cycles plus the DONE cycle.
3. **CPU contention.** During a scroll, drive cpu_req on 100 random cycles with mixed reads and writes outside rows 0–29; insert strobes directly after engine reads as well. Required: the scroll result is identical to test 2, the command runs 100 cycles longer, and every CPU read returns the correct data.
4. **Fill row bounds.** Issue fill row 5 with 0x41. Required: cells 400..479 read 0x41 and all other cells are unchanged. Then issue fill row 30. Required: no writes, done in the next cycle, busy stays 0.
5. **CPU write/read.** Write 0x5A to 0x123, then read 0x123 in the next cycle. Required: cpu_ack on both follow-on cycles and cpu_rdata = 0x5A.
6. **Reset mid-scroll.** Assert reset asynchronously at cycle 1000 of a scroll. Required: busy = 0 and ram_ce = 0 immediately. After reset is released, a new clear command completes normally.

Source files
------------

// File: rtl/charbuf_port_ctrl.sv
// Port-A controller for the text-mode character buffer: CPU bus accesses
// win the port outright; otherwise a clear/scroll/fill-row engine uses it.
module charbuf_port_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_fill,
  input  logic [4:0]  cmd_row,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  localparam logic [11:0] LAST_CELL = 12'(COLS*ROWS - 1);
  localparam logic [11:0] SCR_LAST  = 12'(COLS*(ROWS-1) - 1);
  localparam logic [11:0] SCR_FILL  = 12'(COLS*(ROWS-1));
  localparam logic [11:0] COLS12    = 12'(COLS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCR_RD, S_SCR_WR, S_FILL, S_DONE} state_t;

  state_t      state, state_n;
  logic [11:0] idx, idx_n, last, last_n;
  logic [7:0]  fill_r, fill_n, hold;
  logic        rd_pend, nop_done, nop_n;
  logic        grant, accept, row_ok;
  logic        eng_ce, eng_we;
  logic [11:0] eng_addr, row_base;
  logic [7:0]  eng_din;

  assign grant    = !cpu_req;
  assign accept   = cmd_valid && cmd_ready && (cmd_op != 2'b00);
  assign row_ok   = 32'(cmd_row) < ROWS;
  assign row_base = 12'(32'(cmd_row) * COLS);

  // Out-of-range fill-row passes through DONE without ever raising busy.
  assign busy      = (state != S_IDLE) && !(state == S_DONE && nop_done);
  assign cmd_ready = !busy;
  assign done      = (state == S_DONE);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    last_n   = last;
    fill_n   = fill_r;
    nop_n    = nop_done;
    eng_ce   = 1'b0;
    eng_we   = 1'b0;
    eng_addr = idx;
    eng_din  = fill_r;
    case (state)
      S_IDLE: ;
      S_DONE: begin
        state_n = S_IDLE;
        nop_n   = 1'b0;
      end
      S_CLEAR, S_FILL: begin
        eng_ce = 1'b1;
        eng_we = 1'b1;
        if (grant) begin
          idx_n = idx + 12'd1;
          if (idx == last) state_n = S_DONE;
        end
      end
      S_SCR_RD: begin
        eng_ce   = 1'b1;
        eng_addr = idx + COLS12;
        if (grant) state_n = S_SCR_WR;
      end
      S_SCR_WR: begin
        eng_ce  = 1'b1;
        eng_we  = 1'b1;
        // Read data is still on ram_dout when the write follows immediately.
        eng_din = rd_pend ? ram_dout : hold;
        if (grant) begin
          if (idx == SCR_LAST) begin
            state_n = S_FILL;
            idx_n   = SCR_FILL;
          end else begin
            state_n = S_SCR_RD;
            idx_n   = idx + 12'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      fill_n = cmd_fill;
      nop_n  = 1'b0;
      idx_n  = '0;
      last_n = LAST_CELL;
      case (cmd_op)
        2'b01: state_n = S_CLEAR;
        2'b10: state_n = (ROWS > 1) ? S_SCR_RD : S_FILL;
        default: begin
          if (row_ok) begin
            state_n = S_FILL;
            idx_n   = row_base;
            last_n  = row_base + COLS12 - 12'd1;
          end else begin
            state_n = S_DONE;
            nop_n   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last     <= '0;
      fill_r   <= '0;
      hold     <= '0;
      rd_pend  <= 1'b0;
      nop_done <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last     <= last_n;
      fill_r   <= fill_n;
      nop_done <= nop_n;
      cpu_ack  <= cpu_req;
      rd_pend  <= (state == S_SCR_RD) && grant;
      if (rd_pend) hold <= ram_dout;
    end
  end

  assign ram_ce    = !reset && (cpu_req || eng_ce);
  assign ram_we    = !reset && (cpu_req ? cpu_we : eng_we);
  assign ram_addr  = cpu_req ? cpu_addr : eng_addr;
  assign ram_din   = cpu_req ? cpu_wdata : eng_din;
  assign cpu_rdata = ram_dout;

endmodule

// File: tb/tb_charbuf_port_ctrl.sv
// Bench for charbuf_port_ctrl: behavioural 4096x8 sync RAM, CPU vector table,
// and hand-written command sequences (clear, scroll, contention, fill, reset).
module tb_charbuf_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_fill;
  logic [4:0]  cmd_row;
  logic        cmd_ready, busy, done;
  logic        ram_ce, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;

  always #5 clk = ~clk;

  charbuf_port_ctrl #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill), .cmd_row(cmd_row),
    .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // RAM model; pre_mode loads a whole pattern in one cycle (1: cell=row, 2: i^5A).
  logic [7:0] mem [4096];
  logic [1:0] pre_mode = 2'd0;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (pre_mode != 2'd0) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= (pre_mode == 2'd1) ? ((i < 2400) ? 8'(i / 80) : 8'(i)) : 8'(i ^ 'h5A);
    end else if (ram_ce) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  logic [7:0] expm [4096];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cells_err();
    int e = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== expm[i]) e++;
    return e;
  endfunction

  task automatic preload(input logic [1:0] mode);
    pre_mode = mode;
    tick();
    pre_mode = 2'd0;
    for (int i = 0; i < 4096; i++)
      expm[i] = (mode == 2'd1) ? ((i < 2400) ? 8'(i / 80) : 8'(i)) : 8'(i ^ 'h5A);
  endtask

  // Expected scroll image on top of the row pattern: row r gets r+1, last row 0.
  task automatic exp_scroll();
    for (int i = 0; i < 2400; i++) expm[i] = (i < 2320) ? 8'(i / 80 + 1) : 8'h00;
  endtask

  // Issue a command and run until done; optional CPU traffic above the screen.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] fill,
                         input logic [4:0] row, input bit contend,
                         output int bcyc, output bit got_done);
    int   strobes = 0, cpu_err = 0;
    bit   pend = 0, pend_rd = 0;
    logic [7:0]  pend_exp = 8'h00;
    logic [11:0] a;
    cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill; cmd_row = row;
    tick();
    cmd_valid = 1'b0; cmd_fill = 8'hEE; cmd_row = 5'd0;
    bcyc = 0; got_done = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pend) begin
        if (cpu_ack !== 1'b1) cpu_err++;
        if (pend_rd && cpu_rdata !== pend_exp) cpu_err++;
      end
      if (busy) bcyc++;
      if (done) begin got_done = 1; break; end
      if (contend && strobes < 100 && (c % 45 == 3 || c % 45 == 4)) begin
        a = 12'(2400 + $urandom_range(0, 1695));
        cpu_req = 1'b1; cpu_addr = a;
        cpu_we = 1'($urandom_range(0, 1)); cpu_wdata = 8'($urandom);
        pend = 1; pend_rd = !cpu_we; pend_exp = expm[a];
        if (cpu_we) expm[a] = cpu_wdata;
        strobes++;
      end else begin
        cpu_req = 1'b0; pend = 0;
      end
      tick();
    end
    cpu_req = 1'b0;
    if (contend) chk({name, "_cpu_err"}, cpu_err, 0);
    chk({name, "_done"}, int'(got_done), 1);
    tick();
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_idle_ready"}, int'(cmd_ready), 1);
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;
  vec_t v[9];

  initial begin
    int b, w0;
    bit d;
    v[0] = '{1'b1, 12'h123, 8'h5A, 8'h00};
    v[1] = '{1'b0, 12'h123, 8'h00, 8'h5A};
    v[2] = '{1'b1, 12'h7FF, 8'h00, 8'h00};
    v[3] = '{1'b1, 12'h800, 8'hFF, 8'h00};
    v[4] = '{1'b0, 12'h7FF, 8'h00, 8'h00};
    v[5] = '{1'b0, 12'h800, 8'h00, 8'hFF};
    v[6] = '{1'b0, 12'h123, 8'h00, 8'h5A};
    v[7] = '{1'b1, 12'hFFF, 8'h3C, 8'h00};
    v[8] = '{1'b0, 12'hFFF, 8'h00, 8'h3C};

    // Reset, with a CPU strobe held to prove the port enables are forced off.
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h001; cpu_wdata = 8'h11;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_fill = 8'h00; cmd_row = 5'd0;
    #12;
    chk("rst_ack", int'(cpu_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_ce", int'(ram_ce), 0);
    chk("rst_we", int'(ram_we), 0);
    cpu_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    tick();

    // CPU access table, back-to-back strobes.
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        cpu_req = 1'b1; cpu_we = v[i].we; cpu_addr = v[i].addr; cpu_wdata = v[i].wd;
      end else cpu_req = 1'b0;
      #1;
      if (i < 9) chk($sformatf("vec%0d_port", i), int'({ram_ce, ram_we, ram_addr}),
                     int'({1'b1, v[i].we, v[i].addr}));
      if (i > 0) begin
        chk($sformatf("vec%0d_ack", i - 1), int'(cpu_ack), 1);
        if (!v[i-1].we) chk($sformatf("vec%0d_rdata", i - 1), int'(cpu_rdata), int'(v[i-1].exp));
      end
      tick();
    end
    chk("ack_drop", int'(cpu_ack), 0);

    // No-op command.
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    cmd_valid = 1'b0;
    chk("noop_busy", int'(busy), 0);
    chk("noop_done", int'(done), 0);
    chk("idle_ce", int'(ram_ce), 0);

    // Clear.
    preload(2'd2);
    w0 = wr_cnt;
    run_cmd("clr", 2'b01, 8'h20, 5'd0, 0, b, d);
    chk("clr_len", b, 2401);
    chk("clr_writes", wr_cnt - w0, 2400);
    for (int i = 0; i < 2400; i++) expm[i] = 8'h20;
    chk("clr_cells", cells_err(), 0);

    // Scroll.
    preload(2'd1);
    run_cmd("scr", 2'b10, 8'h00, 5'd0, 0, b, d);
    chk("scr_len", b, 4721);
    exp_scroll();
    chk("scr_cells", cells_err(), 0);

    // Scroll under CPU contention.
    preload(2'd1);
    run_cmd("cont", 2'b10, 8'h00, 5'd0, 1, b, d);
    chk("cont_len", b, 4821);
    exp_scroll();
    chk("cont_cells", cells_err(), 0);

    // Fill row 5, then out-of-range row 30.
    for (int i = 0; i < 4096; i++) expm[i] = mem[i];
    for (int i = 400; i < 480; i++) expm[i] = 8'h41;
    run_cmd("fill5", 2'b11, 8'h41, 5'd5, 0, b, d);
    chk("fill5_len", b, 81);
    chk("fill5_cells", cells_err(), 0);
    w0 = wr_cnt;
    run_cmd("fill30", 2'b11, 8'h55, 5'd30, 0, b, d);
    chk("fill30_busy_cycles", b, 0);
    chk("fill30_writes", wr_cnt - w0, 0);
    chk("fill30_cells", cells_err(), 0);

    // Reset mid-scroll, then a clean clear.
    preload(2'd1);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_fill = 8'h00;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 999; i++) tick();
    chk("mid_busy", int'(busy), 1);
    chk("mid_ce", int'(ram_ce), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_ce", int'(ram_ce), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    @(negedge clk) reset = 1'b0;
    tick();
    run_cmd("clr2", 2'b01, 8'h11, 5'd0, 0, b, d);
    chk("clr2_len", b, 2401);
    for (int i = 0; i < 2400; i++) expm[i] = 8'h11;
    for (int i = 2400; i < 4096; i++) expm[i] = 8'(i);
    chk("clr2_cells", cells_err(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
